// File: rtl/simpson_pkg.sv
// simpson_pkg: shared constants, types and helpers for the Simpson's-rule
// calculator output stage.
//   BCD_DIGITS / NUM_AN : converter digit count and display anode count
//   SEG_0..SEG_9        : active-low {g,f,e,d,c,b,a} digit patterns
//   SEG_BLANK           : all segments off
//   conv_state_e        : bin2bcd_seq state encoding
//   bcd_add3            : double-dabble nibble correction
//   seg_decode          : BCD nibble to segment pattern
//   bcd_nibble          : nibble select by digit index
//   digit_lit           : leading-zero blanking rule
package simpson_pkg;

    localparam int BCD_DIGITS = 5;
    localparam int NUM_AN     = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    function automatic logic [19:0] bcd_add3(input logic [19:0] d);
        logic [19:0] r;
        r = d;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] bcd_nibble(input logic [19:0] b, input logic [2:0] k);
        logic [3:0] n;
        case (k)
            3'd0:    n = b[3:0];
            3'd1:    n = b[7:4];
            3'd2:    n = b[11:8];
            3'd3:    n = b[15:12];
            3'd4:    n = b[19:16];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // Digit k is lit when it is the units digit or some digit at or above it
    // is nonzero; positions beyond the converter width are always dark.
    function automatic logic digit_lit(input logic [19:0] b, input logic [2:0] k);
        logic lit;
        case (k)
            3'd0:    lit = 1'b1;
            3'd1:    lit = |b[19:4];
            3'd2:    lit = |b[19:8];
            3'd3:    lit = |b[19:12];
            3'd4:    lit = |b[19:16];
            default: lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per cycle.
//   clk, rst : clock and synchronous active-high reset
//   start    : load bin and begin a conversion (honoured in IDLE only)
//   bin      : 16-bit unsigned value to convert
//   bcd      : last completed conversion, five BCD nibbles, units in [3:0]
//   busy     : high in CONV and DONE
//   done     : high in DONE, the cycle in which bcd is written
module bin2bcd_seq
    import simpson_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        busy,
    output logic        done
);

    conv_state_e state_r;
    logic [15:0] shreg_r;
    logic [19:0] scratch_r;
    logic [19:0] bcd_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [35:0] adj_s;
    logic [35:0] shifted_s;

    // One double-dabble iteration: correct the scratch nibbles, then shift.
    always_comb begin
        adj_s     = {bcd_add3(scratch_r), shreg_r};
        shifted_s = adj_s << 1'b1;
    end

    // Converter FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shreg_r   <= 16'd0;
            scratch_r <= 20'd0;
            bcd_r     <= 20'd0;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shreg_r   <= bin;
                        scratch_r <= 20'd0;
                        cnt_r     <= 4'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_CONV;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    scratch_r <= shifted_s[35:16];
                    shreg_r   <= shifted_s[15:0];
                    // Hold the count at 15 on exit so it never wraps.
                    if (cnt_r == 4'd15) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    bcd_r   <= scratch_r;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/result_display.sv
// result_display: converts the calculator result to decimal and drives an
// 8-digit multiplexed active-low seven-segment display with leading-zero
// blanking.
//   REFRESH_DIV : clock cycles each digit stays enabled (>= 2)
//   clk, rst    : clock and synchronous active-high reset
//   result      : 16-bit unsigned value, may change on any cycle
//   seg         : active-low cathodes {g,f,e,d,c,b,a}
//   dp          : active-low decimal point, always off
//   an          : active-low anodes, bit 0 is the rightmost digit
//   bcd         : last completed conversion
//   busy        : conversion in progress
module result_display
    import simpson_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        result,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [NUM_AN-1:0]  an,
    output logic [19:0]        bcd,
    output logic               busy
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);

    logic [15:0]       last_src_r;
    logic              start_s;
    logic              done_s;
    logic [TW-1:0]     tick_cnt_r;
    logic              tick_s;
    logic [2:0]        digit_r;
    logic [2:0]        sel_r;
    logic              scan_on_r;
    logic [2:0]        sel_next_s;
    logic              on_next_s;
    logic [6:0]        seg_next_s;
    logic [NUM_AN-1:0] an_next_s;
    logic [6:0]        seg_r;
    logic [NUM_AN-1:0] an_r;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (result),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done_s)
    );

    // A new conversion is requested only when the converter is fully idle.
    always_comb begin
        start_s = (result != last_src_r) && !busy && !done_s;
    end

    // Remember the value handed to the converter for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_src_r <= 16'd0;
        end else if (start_s) begin
            last_src_r <= result;
        end else begin
            last_src_r <= last_src_r;
        end
    end

    always_comb begin
        tick_s = (tick_cnt_r == TICK_LAST);
    end

    // Free-running refresh counter and digit scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TW{1'b0}};
            digit_r    <= 3'd0;
            sel_r      <= 3'd0;
            scan_on_r  <= 1'b0;
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
            digit_r    <= digit_r + 3'd1;
            sel_r      <= digit_r;
            scan_on_r  <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // The digit shown for the next cycle: the scan index at a tick, else the
    // digit already on display. Nothing is lit before the first tick.
    always_comb begin
        sel_next_s = sel_r;
        on_next_s  = scan_on_r;
        seg_next_s = SEG_BLANK;
        an_next_s  = {NUM_AN{1'b1}};
        if (tick_s) begin
            sel_next_s = digit_r;
            on_next_s  = 1'b1;
        end else begin
            sel_next_s = sel_r;
            on_next_s  = scan_on_r;
        end
        if (on_next_s && digit_lit(bcd, sel_next_s)) begin
            seg_next_s = seg_decode(bcd_nibble(bcd, sel_next_s));
            an_next_s  = ~(NUM_AN'(1) << sel_next_s);
        end else begin
            seg_next_s = SEG_BLANK;
            an_next_s  = {NUM_AN{1'b1}};
        end
    end

    // Segments and anodes switch on the same edge to avoid ghosting.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= {NUM_AN{1'b1}};
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

    localparam int DIV = 4;
    localparam logic [6:0] BL = 7'h7F;

    typedef struct {
        logic [15:0]      val;
        logic [19:0]      bcd;
        logic [7:0][6:0]  seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [19:0] bcd;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];
    logic [19:0] last_bcd;
    vec_t tbl[7];

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .bcd    (bcd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [19:0] e);
        @(posedge clk);
        #1;
        result = v;
        exp_q.push_back(e);
    endtask

    // Wait for the conversion to finish; lat counts edges from the call.
    task automatic wait_done(input int lat);
        int k;
        bit fin;
        logic [19:0] e;
        k = 0;
        fin = 1'b0;
        while (!fin && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                chk("busy_rise", {31'd0, busy}, 32'd1);
            end else if (k == lat - 1) begin
                chk("busy_hold", {31'd0, busy}, 32'd1);
                chk("bcd_hold", {12'd0, bcd}, {12'd0, last_bcd});
            end else if (!busy) begin
                fin = 1'b1;
            end
        end
        chk("latency", k, lat);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bcd", {12'd0, bcd}, {12'd0, e});
            last_bcd = e;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: queue empty, bcd=%0h", bcd);
        end
    endtask

    // Observe one full scan starting at the digit-0 slot.
    task automatic check_scan(input logic [7:0][6:0] es);
        int n;
        logic [7:0] prev;
        logic [7:0] one;
        logic [7:0] ea;
        n = 0;
        prev = an;
        one = 8'h01;
        while (n < 8 * DIV + 8 && !(prev != 8'hFE && an == 8'hFE)) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        chk("scan_sync", {24'd0, an}, 32'h0000_00FE);
        for (int d = 0; d < 8; d++) begin
            ea = (es[d] == BL) ? 8'hFF : ~(one << d);
            for (int c = 0; c < DIV; c++) begin
                chk("an", {24'd0, an}, {24'd0, ea});
                chk("seg", {25'd0, seg}, {25'd0, es[d]});
                @(negedge clk);
            end
        end
        chk("scan_wrap", {24'd0, an}, 32'h0000_00FE);
        chk("dp", {31'd0, dp}, 32'd1);
    endtask

    initial begin
        bit seen_busy;
        tbl[0] = '{16'd6,     20'h00006, {BL, BL, BL, BL, BL, BL, BL, 7'h02}};
        tbl[1] = '{16'd105,   20'h00105, {BL, BL, BL, BL, BL, 7'h79, 7'h40, 7'h12}};
        tbl[2] = '{16'd65535, 20'h65535, {BL, BL, BL, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
        tbl[3] = '{16'd40,    20'h00040, {BL, BL, BL, BL, BL, BL, 7'h19, 7'h40}};
        tbl[4] = '{16'd1000,  20'h01000, {BL, BL, BL, BL, 7'h79, 7'h40, 7'h40, 7'h40}};
        tbl[5] = '{16'd28,    20'h00028, {BL, BL, BL, BL, BL, BL, 7'h24, 7'h00}};
        tbl[6] = '{16'd0,     20'h00000, {BL, BL, BL, BL, BL, BL, BL, 7'h40}};

        rst = 1'b1;
        result = 16'd0;
        last_bcd = 20'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", {24'd0, an}, 32'h0000_00FF);
        chk("rst_seg", {25'd0, seg}, 32'h0000_007F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_bcd", {12'd0, bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // First tick is the fourth edge after reset.
        repeat (3) @(posedge clk);
        #1;
        chk("pre_tick_an", {24'd0, an}, 32'h0000_00FF);
        @(posedge clk);
        #1;
        chk("tick_an", {24'd0, an}, 32'h0000_00FE);
        chk("tick_seg", {25'd0, seg}, 32'h0000_0040);
        seen_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("busy_idle", {31'd0, seen_busy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].val, tbl[i].bcd);
            wait_done(18);
            check_scan(tbl[i].seg);
        end

        // result moves mid-conversion: 4 finishes, then 9 follows at once.
        drive(16'd4, 20'h00004);
        repeat (6) @(posedge clk);
        #1;
        result = 16'd9;
        exp_q.push_back(20'h00009);
        wait_done(12);
        wait_done(18);

        // Reset in the middle of a conversion discards it; 4 restarts.
        drive(16'd4, 20'h00004);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
        chk("mid_rst_an", {24'd0, an}, 32'h0000_00FF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h0000_007F);
        exp_q.delete();
        exp_q.push_back(20'h00004);
        last_bcd = 20'd0;
        rst = 1'b0;
        wait_done(18);
        check_scan({BL, BL, BL, BL, BL, BL, BL, 7'h19});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
